// File: rtl/sort_pkg.sv
// Shared helpers for the parallel rank sorter: default sizes, index width
// and the flat-vector field slicing used by every lane/slot.
package sort_pkg;

  // Default geometry of one sorted vector.
  localparam int SORT_N_DEFAULT = 8;
  localparam int SORT_W_DEFAULT = 16;

  // Index width for n lanes. A 2-lane sorter still needs one index bit,
  // so the result never drops below 1.
  function automatic int sort_idx_w(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Lowest bit of lane (or slot) k inside a flat vector of w-bit fields.
  function automatic int sort_lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sort_rank_row.sv
// One row of the rank sorter. The compare half looks at the live input keys
// and marks which lanes go before this lane; the count half turns the
// registered copy of that row into this lane's output slot number.
module sort_rank_row
  import sort_pkg::*;
#(
  parameter int N    = SORT_N_DEFAULT,
  parameter int W    = SORT_W_DEFAULT,
  parameter int IW   = sort_idx_w(SORT_N_DEFAULT),
  parameter int LANE = 0
) (
  input  logic [N*W-1:0] i_keys,
  input  logic           i_desc,
  output logic [N-1:0]   o_row,
  input  logic [N-1:0]   i_row,
  output logic [IW-1:0]  o_rank
);

  logic [W-1:0]  w_key_self;
  logic [IW-1:0] w_count;

  assign w_key_self = i_keys[sort_lane_lo(LANE, W) +: W];

  // Bit j set when lane j precedes this lane; equal keys fall back to lane
  // order so the result is stable in both directions. Diagonal stays 0.
  always_comb begin
    o_row = '0;
    for (int j = 0; j < N; j++) begin
      if (j != LANE) begin
        if (i_desc) begin
          o_row[j] = (i_keys[sort_lane_lo(j, W) +: W] > w_key_self) ||
                     ((i_keys[sort_lane_lo(j, W) +: W] == w_key_self) && (j < LANE));
        end else begin
          o_row[j] = (i_keys[sort_lane_lo(j, W) +: W] < w_key_self) ||
                     ((i_keys[sort_lane_lo(j, W) +: W] == w_key_self) && (j < LANE));
        end
      end
    end
  end

  // Popcount of the registered row. The diagonal is always 0, so the count
  // tops out at N-1 and always fits in IW bits.
  always_comb begin
    w_count = '0;
    for (int j = 0; j < N; j++) begin
      w_count = w_count + IW'(i_row[j]);
    end
  end

  assign o_rank = w_count;

endmodule

// File: rtl/sort_parallel_pipe.sv
// Three-stage parallel rank sorter with valid/ready on both sides.
//   stage 1: keys + full pairwise precedence matrix
//   stage 2: keys + per-lane rank (row popcount)
//   stage 3: output register, keys scattered to slot = rank
// Every stage owns its valid bit and stalls only when the stage after it
// is full and not moving, so the pipe runs at one vector per cycle.
module sort_parallel_pipe
  import sort_pkg::*;
#(
  parameter int N = SORT_N_DEFAULT,
  parameter int W = SORT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*W-1:0]             in_data,
  input  logic                       in_desc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             out_data,
  output logic [N*sort_idx_w(N)-1:0] out_idx
);

  localparam int IW = sort_idx_w(N);

  // Stage advance chain, evaluated from the output backwards.
  logic w_out_adv;
  logic w_s2_adv;
  logic w_s1_adv;

  // Stage 1 state: keys and the precedence matrix (direction is already
  // folded into the matrix, so it is not carried further).
  logic                      r_s1_valid;
  logic [N-1:0][W-1:0]       r_s1_keys;
  logic [N-1:0][N-1:0]       r_s1_mat;

  // Combinational rows from the live inputs and ranks from stage 1.
  logic [N-1:0][N-1:0]       w_row;
  logic [N-1:0][IW-1:0]      w_rank;

  // Stage 2 state: keys travel alongside their ranks.
  logic                      r_s2_valid;
  logic [N-1:0][W-1:0]       r_s2_keys;
  logic [N-1:0][IW-1:0]      r_s2_rank;

  // Scatter result feeding the output register.
  logic [N-1:0][W-1:0]       w_slot_key;
  logic [N-1:0][IW-1:0]      w_slot_idx;

  // Output register.
  logic                      r_out_valid;
  logic [N*W-1:0]            r_out_data;
  logic [N*IW-1:0]           r_out_idx;

  assign w_out_adv = !r_out_valid || out_ready;
  assign w_s2_adv  = !r_s2_valid  || w_out_adv;
  assign w_s1_adv  = !r_s1_valid  || w_s2_adv;

  // Ready depends only on pipe occupancy and out_ready, never on in_valid.
  assign in_ready  = w_s1_adv;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;

  // One rank row per lane: compare half feeds stage 1, count half reads it.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      sort_rank_row #(
        .N    (N),
        .W    (W),
        .IW   (IW),
        .LANE (gi)
      ) u_row (
        .i_keys (in_data),
        .i_desc (in_desc),
        .o_row  (w_row[gi]),
        .i_row  (r_s1_mat[gi]),
        .o_rank (w_rank[gi])
      );
    end
  endgenerate

  // Stage 1: capture an accepted vector and its comparison matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_keys  <= '0;
      r_s1_mat   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_keys <= in_data;
        r_s1_mat  <= w_row;
      end
    end
  end

  // Stage 2: reduce each matrix row to a rank, keys ride along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_keys  <= '0;
      r_s2_rank  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_keys <= r_s1_keys;
        r_s2_rank <= w_rank;
      end
    end
  end

  // Scatter: ranks form a permutation, so exactly one lane matches each
  // slot and an OR across lanes acts as the slot multiplexer.
  always_comb begin
    w_slot_key = '0;
    w_slot_idx = '0;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < N; i++) begin
        if (r_s2_rank[i] == IW'(s)) begin
          w_slot_key[s] = w_slot_key[s] | r_s2_keys[i];
          w_slot_idx[s] = w_slot_idx[s] | IW'(i);
        end
      end
    end
  end

  // Output register: loads on advance, holds everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else if (w_out_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_slot_key;
        r_out_idx  <= w_slot_idx;
      end
    end
  end

endmodule

// File: tb/tb_sort_parallel_pipe.sv
// Bench for sort_parallel_pipe (N=8, W=16): directed vectors with literal
// expectations, backpressure and mid-flight reset, then randomized traffic
// checked against a stable insertion-sort reference.
module tb_sort_parallel_pipe;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;

  localparam logic [N*W-1:0]  V35  = {16'd4, 16'd8, 16'd2, 16'd7, 16'd1, 16'd9, 16'd3, 16'd5};
  localparam logic [N*W-1:0]  E35D = {16'd9, 16'd8, 16'd7, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [N*IW-1:0] E35X = {3'd2, 3'd6, 3'd4, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3};
  localparam logic [N*W-1:0]  V36  = {16'd1, 16'd9, 16'd0, 16'd9, 16'd4, 16'd1, 16'd4, 16'd4};
  localparam logic [N*W-1:0]  E36D = {16'd0, 16'd1, 16'd1, 16'd4, 16'd4, 16'd4, 16'd9, 16'd9};
  localparam logic [N*IW-1:0] E36X = {3'd5, 3'd7, 3'd2, 3'd3, 3'd1, 3'd0, 3'd6, 3'd4};
  localparam logic [N*W-1:0]  VFF  = {8{16'hFFFF}};
  localparam logic [N*IW-1:0] EFFX = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [N*W-1:0]  VALT = {4{16'hFFFF, 16'h0000}};
  localparam logic [N*W-1:0]  EALD = {{4{16'hFFFF}}, {4{16'h0000}}};
  localparam logic [N*IW-1:0] EALX = {3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd4, 3'd2, 3'd0};

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic            in_desc;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out_data;
  logic [N*IW-1:0] out_idx;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  logic strict = 1'b1;

  typedef struct {
    logic [N*W-1:0]  d;
    logic [N*IW-1:0] x;
    int              c;
  } exp_t;

  exp_t expq[$];

  sort_parallel_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: stable insertion sort of lane numbers by key.
  function automatic exp_t model(input logic [N*W-1:0] d, input logic desc);
    exp_t         r;
    logic [W-1:0] k[N];
    int           ord[N];
    int           cur;
    int           j;
    logic         first;
    for (int i = 0; i < N; i++) begin
      k[i]   = d[i*W +: W];
      ord[i] = i;
    end
    for (int i = 1; i < N; i++) begin
      cur = ord[i];
      j   = i - 1;
      while (j >= 0) begin
        first = desc ? (k[cur] > k[ord[j]]) : (k[cur] < k[ord[j]]);
        if (!first) break;
        ord[j+1] = ord[j];
        j = j - 1;
      end
      ord[j+1] = cur;
    end
    r.d = '0;
    r.x = '0;
    r.c = 0;
    for (int s = 0; s < N; s++) begin
      r.d[s*W +: W]   = k[ord[s]];
      r.x[s*IW +: IW] = IW'(ord[s]);
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    int             kind;
    kind = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      if (kind == 0)      v[i*W +: W] = W'($urandom_range(0, 3));
      else if (kind == 1) v[i*W +: W] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      else                v[i*W +: W] = W'($urandom);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Present a vector from posedge+1 until accepted; returns the accept cycle.
  task automatic send(input logic [N*W-1:0] d, input logic desc, output int ac);
    logic took;
    int   t;
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = desc;
    took     = 1'b0;
    t        = 0;
    ac       = -1;
    while (!took && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        took = 1'b1;
        ac   = cyc;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
    end
  endtask

  // Wait for the next output and pin it against literal values.
  task automatic expect_lit(input string name, input logic [N*W-1:0] ed,
                            input logic [N*IW-1:0] ex, input int ac);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, 128'(out_valid), 128'(1));
    chk({name, "_data"},  128'(out_data),  128'(ed));
    chk({name, "_idx"},   128'(out_idx),   128'(ex));
    chk({name, "_lat"},   128'(cyc - ac),  128'(3));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, 128'(expq.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  // Compare process: log accepts into the model queue, check every
  // delivered output and the hold-while-stalled rule.
  task automatic monitor();
    exp_t            e;
    logic            hold;
    logic [N*W-1:0]  pd;
    logic [N*IW-1:0] px;
    hold = 1'b0;
    pd   = '0;
    px   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 128'(out_valid), 128'(1));
          chk("hold_data",  128'(out_data),  128'(pd));
          chk("hold_idx",   128'(out_idx),   128'(px));
        end
        if (in_valid && in_ready) begin
          e   = model(in_data, in_desc);
          e.c = cyc;
          expq.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_output", 128'(1), 128'(0));
          end else begin
            e = expq.pop_front();
            chk("out_data", 128'(out_data), 128'(e.d));
            chk("out_idx",  128'(out_idx),  128'(e.x));
            if (strict) chk("latency", 128'(cyc - e.c), 128'(3));
          end
        end
        hold = out_valid && !out_ready;
        pd   = out_data;
        px   = out_idx;
      end
    end
  endtask

  task automatic run();
    exp_t e;
    int   ac;
    int   c0;
    int   bpac[6];
    int   bpexp[6];
    logic done;

    bpexp = '{0, 1, 2, 3, 10, 11};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_desc   = 1'b0;
    out_ready = 1'b1;

    // Reference pinned by hand-derived sorts.
    e = model(V35, 1'b0);
    chk("model_asc_data",  128'(e.d), 128'(E35D));
    chk("model_asc_idx",   128'(e.x), 128'(E35X));
    e = model(V36, 1'b1);
    chk("model_desc_data", 128'(e.d), 128'(E36D));
    chk("model_desc_idx",  128'(e.x), 128'(E36X));

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_out_idx",   128'(out_idx),   128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Directed vectors, no stall.
    send(V35, 1'b0, ac);  expect_lit("asc_distinct", E35D, E35X, ac);
    send(V36, 1'b1, ac);  expect_lit("desc_ties",    E36D, E36X, ac);
    send(VFF, 1'b0, ac);  expect_lit("all_ffff",     VFF,  EFFX, ac);
    send(VALT, 1'b0, ac); expect_lit("alt_asc",      EALD, EALX, ac);

    // Mixed directions back to back.
    send(V36, 1'b0, ac);
    send(V36, 1'b1, ac);
    send(V35, 1'b1, ac);
    send(VALT, 1'b1, ac);
    drain("mixed_drain");

    // Backpressure: six vectors, out_ready low in cycles 4..9.
    strict = 1'b0;
    c0 = cyc;
    fork
      begin
        for (int k = 0; k < 6; k++) send(rand_vec(), 1'($urandom_range(0, 1)), bpac[k]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 6; k++) chk($sformatf("bp_accept%0d", k), 128'(bpac[k] - c0), 128'(bpexp[k]));
    drain("bp_drain");

    // Reset two cycles after an accept: nothing may emerge afterwards.
    strict = 1'b1;
    send(V35, 1'b0, ac);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'(0));
    chk("async_rst_data",  128'(out_data),  128'(0));
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 128'(out_valid), 128'(0));
    end
    @(posedge clk);
    #1;
    send(V36, 1'b1, ac);
    expect_lit("post_rst", E36D, E36X, ac);

    // Randomized traffic with 70% out_ready.
    strict = 1'b0;
    done   = 1'b0;
    fork
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 99) < 70);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_vec(), 1'($urandom_range(0, 1)), ac);
        end
        done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      run();
    join
  end

endmodule
